// File: rtl/reg_readout_serializer_pkg.sv
// Shared types and defaults for the register readout serializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_readout_serializer_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_BIT_DIV = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter width that stays at least 1 bit when the count range collapses to one value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_readout_serializer_if.sv
// Request, register-bank read port and serial output bundle of the readout serializer.
// Latency: n/a (wiring only).
// Backpressure: none; the serializer ignores rd_req while busy.
interface reg_readout_serializer_if
  import reg_readout_serializer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] bank_addr;
  logic [WIDTH-1:0]  bank_data;
  logic              sdo;
  logic              sdo_valid;
  logic              sdo_last;
  logic              busy;
  logic              done;

  // Requester plus register bank side.
  modport master (
    output rd_req, rd_addr, bank_data,
    input  bank_addr, sdo, sdo_valid, sdo_last, busy, done
  );

  // Serializer side.
  modport slave (
    input  rd_req, rd_addr, bank_data,
    output bank_addr, sdo, sdo_valid, sdo_last, busy, done
  );

endinterface

// File: rtl/reg_readout_serializer_bit_timer.sv
// Bit timer: div_cnt paces each serial bit for BIT_DIV cycles, bit_cnt indexes the frame bit.
// Latency: tick on the last cycle of every bit; counters restart at 0 whenever i_en is low.
// Backpressure: none; free-running while enabled.
module reg_readout_serializer_bit_timer
  import reg_readout_serializer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int BIT_DIV = DEF_BIT_DIV
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_en,
  output logic                      o_bit_tick,
  output logic                      o_last_bit,
  output logic [cnt_w(WIDTH)-1:0]   o_bit_cnt
);

  localparam int DIV_W = cnt_w(BIT_DIV);
  localparam int BIT_W = cnt_w(WIDTH);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BIT_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(WIDTH - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             w_tick;

  assign w_tick     = i_en && (r_div_cnt == DIV_MAX);
  assign o_bit_tick = w_tick;
  assign o_last_bit = (r_bit_cnt == BIT_MAX);
  assign o_bit_cnt  = r_bit_cnt;

  // Hold both counters at zero until enabled, then advance the bit index once per BIT_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (!i_en) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_bit_cnt <= r_bit_cnt + BIT_W'(1);
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/reg_readout_serializer.sv
// Reads one register-bank word on request and shifts it out MSB-first on sdo with valid/last strobes.
// Latency: first bit visible one cycle after the fetch cycle; busy lasts 2 + WIDTH*BIT_DIV cycles.
// Backpressure: none; rd_req is only sampled in IDLE and dropped otherwise.
module reg_readout_serializer
  import reg_readout_serializer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BIT_DIV = DEF_BIT_DIV
) (
  input  logic                    clk,
  input  logic                    reset,
  reg_readout_serializer_if.slave bus
);

  localparam int BIT_W = cnt_w(WIDTH);
  // sdo_last is raised when the bit index is about to step onto the final bit.
  localparam logic [BIT_W-1:0] PRE_LAST = BIT_W'(WIDTH - 2);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr_q;
  logic [WIDTH-1:0]  r_shreg;
  logic              r_sdo_valid;
  logic              r_sdo_last;
  logic              r_busy;
  logic              r_done;

  logic              w_shift_en;
  logic              w_bit_tick;
  logic              w_last_bit;
  logic [BIT_W-1:0]  w_bit_cnt;

  assign w_shift_en = (r_state == ST_SHIFT);

  reg_readout_serializer_bit_timer #(
    .WIDTH   (WIDTH),
    .BIT_DIV (BIT_DIV)
  ) u_bit_timer (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_shift_en),
    .o_bit_tick (w_bit_tick),
    .o_last_bit (w_last_bit),
    .o_bit_cnt  (w_bit_cnt)
  );

  // The shift register is zero outside a frame, so its MSB doubles as the registered sdo.
  assign bus.bank_addr = r_addr_q;
  assign bus.sdo       = r_shreg[WIDTH-1];
  assign bus.sdo_valid = r_sdo_valid;
  assign bus.sdo_last  = r_sdo_last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  // Frame sequencer: accept, fetch the word, shift it out, pulse done, return to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr_q    <= '0;
      r_shreg     <= '0;
      r_sdo_valid <= 1'b0;
      r_sdo_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.rd_req) begin
            r_addr_q <= bus.rd_addr;
            r_busy   <= 1'b1;
            r_state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // The bank answers combinationally for bank_addr, so the word is ready now.
          r_shreg     <= bus.bank_data;
          r_sdo_valid <= 1'b1;
          r_sdo_last  <= 1'b0;
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_bit_tick) begin
            if (w_last_bit) begin
              r_shreg     <= '0;
              r_sdo_valid <= 1'b0;
              r_sdo_last  <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_shreg    <= {r_shreg[WIDTH-2:0], 1'b0};
              r_sdo_last <= (w_bit_cnt == PRE_LAST);
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_readout_serializer.sv
// Scoreboard bench: two serializers (BIT_DIV 1 and 3) reading a shared random register bank.
// Latency: expectations are queued at request time and matched when frames appear.
// Backpressure: requests are only issued while the addressed serializer is idle, except in the held-request run.
module tb_reg_readout_serializer;
  import reg_readout_serializer_pkg::*;

  localparam int W  = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  word;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  reg_readout_serializer_if #(.WIDTH(W), .ADDR_W(AW)) bus0 ();
  reg_readout_serializer_if #(.WIDTH(W), .ADDR_W(AW)) bus1 ();

  logic [W-1:0] bank [32];
  assign bus0.bank_data = bank[bus0.bank_addr];
  assign bus1.bank_data = bank[bus1.bank_addr];

  reg_readout_serializer #(.WIDTH(W), .ADDR_W(AW), .BIT_DIV(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  reg_readout_serializer #(.WIDTH(W), .ADDR_W(AW), .BIT_DIV(3)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  logic [1:0]    m_sdo, m_vld, m_last, m_busy, m_done;
  logic [AW-1:0] m_baddr [2];
  assign m_sdo      = {bus1.sdo,       bus0.sdo};
  assign m_vld      = {bus1.sdo_valid, bus0.sdo_valid};
  assign m_last     = {bus1.sdo_last,  bus0.sdo_last};
  assign m_busy     = {bus1.busy,      bus0.busy};
  assign m_done     = {bus1.done,      bus0.done};
  assign m_baddr[0] = bus0.bank_addr;
  assign m_baddr[1] = bus1.bank_addr;

  // Scoreboard queues, filled by stimulus, drained by the monitor.
  exp_t exp_q0 [$];
  exp_t exp_q1 [$];

  // Flags written only by the stimulus process.
  bit rst_chk   = 1'b1;
  bit gap_chk0  = 1'b0;
  bit final_chk = 1'b0;
  int to_req    = 0;

  // Monitor-owned state.
  int   total = 0;
  int   bad   = 0;
  int   to_seen = 0;
  bit   final_seen = 1'b0;
  exp_t cur [2];
  bit   in_frame [2];
  bit   exp_done [2];
  bit   busy_prev [2];
  bit   seen_frame [2];
  int   vcnt [2];
  int   blen [2];
  int   idle_len [2];

  task automatic check(input string nm, input int k, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h (t=%0t)", nm, k, got, want, $time);
    end
  endtask

  // Reference model of the serial frame: bit i of the frame is word[W-1-i], held BIT_DIV cycles.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int div;
      int idx;
      int qs;
      div = (k == 0) ? 1 : 3;
      if (reset) begin
        if (rst_chk) begin
          check("rst_outputs", k, 64'({m_sdo[k], m_vld[k], m_last[k], m_busy[k], m_done[k]}), 64'(0));
          check("rst_bank_addr", k, 64'(m_baddr[k]), 64'(0));
        end
        in_frame[k]   = 1'b0;
        exp_done[k]   = 1'b0;
        busy_prev[k]  = 1'b0;
        seen_frame[k] = 1'b0;
        vcnt[k]       = 0;
        blen[k]       = 0;
        idle_len[k]   = 0;
      end else begin
        check("done", k, 64'(m_done[k]), 64'(exp_done[k]));
        exp_done[k] = 1'b0;
        if (m_busy[k] && !busy_prev[k]) begin
          if (k == 0 && gap_chk0 && seen_frame[0])
            check("idle_gap", k, 64'(idle_len[k]), 64'(1));
          qs = (k == 0) ? exp_q0.size() : exp_q1.size();
          check("frame_expected", k, 64'(qs > 0), 64'(1));
          if (qs > 0) cur[k] = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          else        cur[k] = '0;
          in_frame[k]   = 1'b1;
          seen_frame[k] = 1'b1;
          vcnt[k]       = 0;
          blen[k]       = 0;
        end
        if (m_busy[k]) begin
          blen[k]++;
          idle_len[k] = 0;
          check("bank_addr", k, 64'(m_baddr[k]), 64'(cur[k].addr));
        end else begin
          idle_len[k]++;
        end
        if (!m_busy[k] && busy_prev[k]) begin
          check("busy_len", k, 64'(blen[k]), 64'(2 + W * div));
          check("frame_complete", k, 64'(in_frame[k]), 64'(0));
        end
        if (m_vld[k]) begin
          check("valid_in_frame", k, 64'(in_frame[k]), 64'(1));
          if (in_frame[k]) begin
            idx = vcnt[k] / div;
            check("sdo", k, 64'(m_sdo[k]), 64'(cur[k].word[W-1-idx]));
            check("sdo_last", k, 64'(m_last[k]), 64'(idx == W - 1));
            vcnt[k]++;
            if (vcnt[k] == W * div) begin
              in_frame[k] = 1'b0;
              exp_done[k] = 1'b1;
            end
          end
        end else begin
          check("idle_sdo_last", k, 64'({m_sdo[k], m_last[k]}), 64'(0));
        end
        busy_prev[k] = m_busy[k];
      end
    end
    if (to_req != to_seen) begin
      check("timeout", 0, 64'(to_req), 64'(to_seen));
      to_seen = to_req;
    end
    if (final_chk && !final_seen) begin
      check("q0_drained", 0, 64'(exp_q0.size()), 64'(0));
      check("q1_drained", 1, 64'(exp_q1.size()), 64'(0));
      final_seen = 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic [AW-1:0] a);
    exp_t e;
    e.addr = a;
    e.word = bank[a];
    if (k == 0) begin
      bus0.rd_req  = 1'b1;
      bus0.rd_addr = a;
      exp_q0.push_back(e);
    end else begin
      bus1.rd_req  = 1'b1;
      bus1.rd_addr = a;
      exp_q1.push_back(e);
    end
  endtask

  // Drop requests and scramble addresses so late address changes are exercised.
  task automatic release_req;
    bus0.rd_req  = 1'b0;
    bus1.rd_req  = 1'b0;
    bus0.rd_addr = AW'($urandom);
    bus1.rd_addr = AW'($urandom);
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    tick();
    while ((bus0.busy || bus1.busy) && n < 400) begin
      tick();
      n++;
    end
    if (bus0.busy || bus1.busy) to_req++;
  endtask

  task automatic run_pair(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    issue(0, a0);
    issue(1, a1);
    tick();
    release_req();
    wait_idle();
  endtask

  initial begin
    bus0.rd_req  = 1'b0;
    bus1.rd_req  = 1'b0;
    bus0.rd_addr = '0;
    bus1.rd_addr = '0;
    for (int i = 0; i < 32; i++) bank[i] = $urandom;
    bank[0] = 32'h0000_0000;
    bank[1] = 32'h8000_0001;
    bank[5] = 32'hA5A5_0F0F;

    rst_chk = 1'b1;
    reset   = 1'b1;
    repeat (3) tick();
    reset   = 1'b0;
    rst_chk = 1'b0;
    tick();

    run_pair(5'd5, 5'd1);
    run_pair(5'd0, 5'd0);
    for (int i = 0; i < 6; i++) run_pair(AW'($urandom), AW'($urandom));

    // rd_req held high with the address toggling 3/7; accepts land every 2 + W + 1 edges.
    for (int t = 0; t < 3 * (W + 3); t++) begin
      logic [AW-1:0] a;
      a = (t % 2 == 1) ? 5'd7 : 5'd3;
      bus0.rd_req  = 1'b1;
      bus0.rd_addr = a;
      if (t % (W + 3) == 0) begin
        exp_t e;
        e.addr = a;
        e.word = bank[a];
        exp_q0.push_back(e);
      end
      if (t == 2) gap_chk0 = 1'b1;
      tick();
    end
    release_req();
    gap_chk0 = 1'b0;
    wait_idle();

    // Abandon a frame with an asynchronous reset while bit 10 is on sdo.
    issue(0, AW'($urandom_range(1, 31)));
    tick();
    release_req();
    repeat (11) tick();
    #1;
    rst_chk = 1'b1;
    reset   = 1'b1;
    tick();
    tick();
    reset   = 1'b0;
    rst_chk = 1'b0;
    tick();

    issue(0, 5'd2);
    tick();
    release_req();
    wait_idle();

    repeat (3) tick();
    final_chk = 1'b1;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
